proc_control_unit: RTL and testbench
====================================

PROC_CONTROL_UNIT -- requirements
Module: proc_control_unit

Interface
REQ-001 Parameter DATA_W, 16, instruction word width.
REQ-002 Parameter NREG, 8, number of general registers (one-hot Rin width).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  start request; sampled only in state T0.
REQ-006 IR  input  DATA_W  current instruction: [15:13] opcode, [12] imm flag, [11:9] rX, [8:0] immediate, [2:0] rY.
REQ-007 IRin  output  1  load IR from Din at next edge.
REQ-008 Rin  output  NREG  one-hot register write enable, index rX.
REQ-009 Select  output  4  bus source: 0-7 R0-R7, 8 G, 9 IR[8:0] zero-extended, 10 {IR[7:0],8'h00}, 15 none.
REQ-010 Ain  output  1  load A register from bus.
REQ-011 Gin  output  1  load G register from ALU.
REQ-012 AddSub  output  1  ALU operation: 0 add, 1 subtract.
REQ-013 done  output  1  one-cycle pulse in the final step of every instruction.
REQ-014 busy  output  1  high while state is not T0.
REQ-015 illegal  output  1  one-cycle pulse with done for an undefined opcode.
REQ-016 Tstep_Q  output  2  current step state, for debug.
REQ-017 instr_count  output  16  count of retired instructions.

Function
REQ-018 The FSM SHALL have states T0=0, T1=1, T2=2, T3=3; outputs are decoded combinationally from state and IR (Moore per step).
REQ-019 T0: run=1 -> IRin=1, next T1; run=0 -> stay in T0, all enables 0, Select=15.
REQ-020 Opcodes: 000 mv, 001 mvt, 010 add, 011 sub; 100-111 are illegal.
REQ-021 mv in T1: Select=rY (imm=0) or 9 (imm=1); Rin[rX]=1; done=1; next T0.
REQ-022 mvt in T1: Select=10; Rin[rX]=1; done=1; next T0.
REQ-023 add/sub in T1: Select=rX; Ain=1; next T2.
REQ-024 add/sub in T2: Select=rY (imm=0) or 9 (imm=1); Gin=1; AddSub=opcode[0]; next T3.
REQ-025 add/sub in T3: Select=8; Rin[rX]=1; done=1; next T0.
REQ-026 Illegal opcode in T1: no enables, Select=15, done=1, illegal=1; next T0.
REQ-027 Latency run-to-done: mv/mvt 2 cycles, add/sub 4 cycles, illegal 2 cycles.
REQ-028 run is ignored outside T0; deasserting it mid-instruction does not abort the instruction.
REQ-029 Back-to-back: with run held at 1, a new IRin occurs in the cycle after done.
REQ-030 Rin SHALL be one-hot or zero; no two enables of Rin/Ain/Gin/IRin are driven by the same step except as listed.
REQ-031 instr_count increments by 1 on each done (illegal included), wrapping 16'hFFFF -> 16'h0000.

Reset
REQ-032 While reset=0: state T0; IRin, Rin, Ain, Gin, AddSub, done, busy, illegal = 0; Select=15; instr_count=0.
REQ-033 Reset asserted mid-instruction SHALL abort it with no further register write; after release the FSM waits for run in T0.

Structure
REQ-034 A shared package SHALL hold opcode constants, step state encoding T0-T3, and the Select source codes.
REQ-035 One sub-module dec3to8 (3-bit to one-hot 8 decoder) SHALL generate Rin from rX.

Verification
REQ-036 reset=0 for 2 cycles then release, run=0 -> Tstep_Q=0, Select=15, busy=0, instr_count=0 held.
REQ-037 run=1, IR=16'h0000+rX=1,rY=0 (mv R1,R0) -> cycle1 IRin=1; cycle2 Select=0, Rin=8'b00000010, done=1.
REQ-038 IR=001 rX=1 imm=8'hA5 (mvt) -> T1 Select=10, Rin=8'b00000010, done=1, instr_count+1.
REQ-039 sub R1,R2 (IR=16'h6202) -> T1 Select=1,Ain; T2 Select=2,Gin,AddSub=1; T3 Select=8,Rin[1],done.
REQ-040 opcode 111 -> T1 done=1, illegal=1, Rin=0; reset=0 asserted in T2 of an add -> Tstep_Q=0, Rin never asserted.
REQ-041 instr_count preset near wrap via 65536 retired mv instructions -> reads 16'h0000 after the last done.

Source files
------------

// File: rtl/proc_control_unit_pkg.sv
// +-------------------------------------------------------------------------
// | proc_control_unit_pkg : opcodes, step encoding and bus-select codes
// | Revision: 1.0
// +-------------------------------------------------------------------------
`default_nettype none

package proc_control_unit_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [3:0] SEL_G      = 4'd8;
  localparam logic [3:0] SEL_IMM    = 4'd9;
  localparam logic [3:0] SEL_IMM_HI = 4'd10;
  localparam logic [3:0] SEL_NONE   = 4'd15;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/proc_control_unit_if.sv
// +-------------------------------------------------------------------------
// | proc_control_unit_if : instruction/run inputs and datapath control outputs
// | Revision: 1.0
// +-------------------------------------------------------------------------
`default_nettype none

interface proc_control_unit_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
);
  logic              run;
  logic [DATA_W-1:0] IR;
  logic              IRin;
  logic [NREG-1:0]   Rin;
  logic [3:0]        Select;
  logic              Ain;
  logic              Gin;
  logic              AddSub;
  logic              done;
  logic              busy;
  logic              illegal;
  logic [1:0]        Tstep_Q;
  logic [15:0]       instr_count;

  modport master (
    output run, IR,
    input  IRin, Rin, Select, Ain, Gin, AddSub, done, busy, illegal,
           Tstep_Q, instr_count
  );

  modport slave (
    input  run, IR,
    output IRin, Rin, Select, Ain, Gin, AddSub, done, busy, illegal,
           Tstep_Q, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/proc_control_unit_dec3to8.sv
// +-------------------------------------------------------------------------
// | dec3to8 : 3-bit to one-hot 8 decoder with enable
// | Revision: 1.0
// +-------------------------------------------------------------------------
`default_nettype none

module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] onehot
);
  assign onehot = en ? (8'b0000_0001 << sel) : 8'b0000_0000;
endmodule

`default_nettype wire

// File: rtl/proc_control_unit.sv
// +-------------------------------------------------------------------------
// | proc_control_unit : four-step control FSM for a simple mv/mvt/add/sub CPU
// | Revision: 1.0
// +-------------------------------------------------------------------------
`default_nettype none

module proc_control_unit
  import proc_control_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic                clock,
  input  logic                reset,
  proc_control_unit_if.slave  bus
);

  step_t             r_state;
  logic [15:0]       r_count;
  logic [DATA_W-1:0] w_ir;
  logic [2:0]        w_op;
  logic              w_imm;
  logic [2:0]        w_rx;
  logic [2:0]        w_ry;
  logic              w_irin;
  logic              w_rin_en;
  logic              w_ain;
  logic              w_gin;
  logic              w_addsub;
  logic              w_done;
  logic              w_illegal;
  logic [3:0]        w_sel;
  logic [7:0]        w_rin_onehot;
  logic              w_unused_ir_bits;

  assign w_ir             = bus.IR;
  assign w_op             = w_ir[15:13];
  assign w_imm            = w_ir[12];
  assign w_rx             = w_ir[11:9];
  assign w_ry             = w_ir[2:0];
  assign w_unused_ir_bits = ^w_ir[8:3];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= T0;
      r_count <= 16'h0000;
    end else begin
      case (r_state)
        T0:      if (bus.run) r_state <= T1;
        T1:      r_state <= is_arith(w_op) ? T2 : T0;
        T2:      r_state <= T3;
        default: r_state <= T0;
      endcase
      if (w_done) r_count <= r_count + 16'd1;
    end
  end

  // Reset gates IRin so no IR load is requested while the unit is held in reset.
  always_comb begin
    w_irin    = 1'b0;
    w_rin_en  = 1'b0;
    w_ain     = 1'b0;
    w_gin     = 1'b0;
    w_addsub  = 1'b0;
    w_done    = 1'b0;
    w_illegal = 1'b0;
    w_sel     = SEL_NONE;
    case (r_state)
      T0: w_irin = bus.run & reset;
      T1: begin
        case (w_op)
          OP_MV: begin
            w_sel    = w_imm ? SEL_IMM : {1'b0, w_ry};
            w_rin_en = 1'b1;
            w_done   = 1'b1;
          end
          OP_MVT: begin
            w_sel    = SEL_IMM_HI;
            w_rin_en = 1'b1;
            w_done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_sel = {1'b0, w_rx};
            w_ain = 1'b1;
          end
          default: begin
            w_done    = 1'b1;
            w_illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        w_sel    = w_imm ? SEL_IMM : {1'b0, w_ry};
        w_gin    = 1'b1;
        w_addsub = w_op[0];
      end
      default: begin
        w_sel    = SEL_G;
        w_rin_en = 1'b1;
        w_done   = 1'b1;
      end
    endcase
  end

  dec3to8 u_dec3to8 (
    .en     (w_rin_en),
    .sel    (w_rx),
    .onehot (w_rin_onehot)
  );

  assign bus.IRin        = w_irin;
  assign bus.Rin         = NREG'(w_rin_onehot);
  assign bus.Select      = w_sel;
  assign bus.Ain         = w_ain;
  assign bus.Gin         = w_gin;
  assign bus.AddSub      = w_addsub;
  assign bus.done        = w_done;
  assign bus.illegal     = w_illegal;
  assign bus.busy        = (r_state != T0);
  assign bus.Tstep_Q     = r_state;
  assign bus.instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_proc_control_unit.sv
// +-------------------------------------------------------------------------
// | tb_proc_control_unit : scoreboard bench for proc_control_unit
// | Revision: 1.0
// +-------------------------------------------------------------------------
`default_nettype none

module tb_proc_control_unit;
  import proc_control_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  proc_control_unit_if #(.DATA_W(16), .NREG(8)) bus ();

  proc_control_unit #(.DATA_W(16), .NREG(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] rin;
    logic ain, gin, addsub, done, illegal;
  } st_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [1:0]  n;
    st_t         s1, s2, s3;
  } vec_t;

  typedef struct packed {
    logic        irin;
    logic [7:0]  rin;
    logic        ain, gin, addsub, done, illegal, busy;
    logic [1:0]  tstep;
    logic [3:0]  sel;
    logic [15:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        mon_a, mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_cnt = 16'h0000;
  vec_t        vt[9];

  function automatic st_t st(input logic [3:0] sel, input logic [7:0] rin,
                             input logic ain, input logic gin, input logic addsub,
                             input logic done, input logic illegal);
    st_t r;
    r.sel = sel; r.rin = rin; r.ain = ain; r.gin = gin;
    r.addsub = addsub; r.done = done; r.illegal = illegal;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.irin = bus.IRin; a.rin = bus.Rin; a.ain = bus.Ain; a.gin = bus.Gin;
    a.addsub = bus.AddSub; a.done = bus.done; a.illegal = bus.illegal;
    a.busy = bus.busy; a.tstep = bus.Tstep_Q; a.sel = bus.Select;
    a.cnt = bus.instr_count;
    return a;
  endfunction

  task automatic push(input logic irin, input st_t s, input logic busy, input logic [1:0] tstep);
    obs_t e;
    e.irin = irin; e.rin = s.rin; e.ain = s.ain; e.gin = s.gin;
    e.addsub = s.addsub; e.done = s.done; e.illegal = s.illegal;
    e.busy = busy; e.tstep = tstep; e.sel = s.sel; e.cnt = model_cnt;
    exp_q.push_back(e);
    if (s.done) model_cnt = model_cnt + 16'd1;
  endtask

  // Starts just after a rising edge with the FSM in T0; returns likewise.
  task automatic exec(input vec_t v, input bit hold_run, input bit drop_mid);
    st_t s;
    bus.IR  = v.ir;
    bus.run = 1'b1;
    push(1'b1, st(SEL_NONE, 8'h00, 0, 0, 0, 0, 0), 1'b0, 2'd0);
    for (int k = 1; k <= int'(v.n); k++) begin
      s = (k == 1) ? v.s1 : (k == 2) ? v.s2 : v.s3;
      push(1'b0, s, 1'b1, 2'(k));
    end
    @(posedge clock); #1;
    if (drop_mid) bus.run = 1'b0;
    repeat (int'(v.n)) begin
      @(posedge clock); #1;
    end
    if (!hold_run) bus.run = 1'b0;
  endtask

  task automatic check_idle(input string name, input logic [15:0] cnt);
    obs_t e;
    obs_t a;
    a = sample();
    e = '0;
    e.sel = SEL_NONE;
    e.cnt = cnt;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, a, e);
    end
  endtask

  always @(negedge clock) begin
    if (bus.busy || bus.IRin || bus.done) begin
      mon_a = sample();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h expected none", mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL step got %h expected %h", mon_a, mon_e);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached, queue=%0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0;
    bus.IR  = 16'h0000;
    vt[0] = '{16'h0200, 2'd1, st(4'd0,  8'h02, 0, 0, 0, 1, 0), '0, '0};
    vt[1] = '{16'h22A5, 2'd1, st(4'd10, 8'h02, 0, 0, 0, 1, 0), '0, '0};
    vt[2] = '{16'h6202, 2'd3, st(4'd1,  8'h00, 1, 0, 0, 0, 0),
              st(4'd2, 8'h00, 0, 1, 1, 0, 0), st(4'd8, 8'h02, 0, 0, 0, 1, 0)};
    vt[3] = '{16'hE000, 2'd1, st(4'd15, 8'h00, 0, 0, 0, 1, 1), '0, '0};
    vt[4] = '{16'h161F, 2'd1, st(4'd9,  8'h08, 0, 0, 0, 1, 0), '0, '0};
    vt[5] = '{16'h5E05, 2'd3, st(4'd7,  8'h00, 1, 0, 0, 0, 0),
              st(4'd9, 8'h00, 0, 1, 0, 0, 0), st(4'd8, 8'h80, 0, 0, 0, 1, 0)};
    vt[6] = '{16'h4806, 2'd3, st(4'd4,  8'h00, 1, 0, 0, 0, 0),
              st(4'd6, 8'h00, 0, 1, 0, 0, 0), st(4'd8, 8'h10, 0, 0, 0, 1, 0)};
    vt[7] = '{16'h8000, 2'd1, st(4'd15, 8'h00, 0, 0, 0, 1, 1), '0, '0};
    vt[8] = '{16'h0005, 2'd1, st(4'd5,  8'h01, 0, 0, 0, 1, 0), '0, '0};

    // Reset held for two cycles; run raised in the second must not load IR.
    @(negedge clock); check_idle("reset_cycle1", 16'h0000);
    bus.run = 1'b1;
    @(negedge clock); check_idle("reset_cycle2_run", 16'h0000);
    bus.run = 1'b0;
    reset   = 1'b1;
    @(negedge clock); check_idle("idle_after_release", 16'h0000);
    @(negedge clock); check_idle("idle_held", 16'h0000);

    @(posedge clock); #1;
    exec(vt[0], 1'b0, 1'b0);
    exec(vt[1], 1'b0, 1'b0);
    exec(vt[2], 1'b0, 1'b1);
    for (int i = 3; i <= 8; i++) exec(vt[i], (i != 8), 1'b0);
    @(negedge clock); check_idle("idle_after_b2b", model_cnt);

    // Abort an add in T2 with reset: no Rin, count cleared.
    @(posedge clock); #1;
    bus.IR  = vt[6].ir;
    bus.run = 1'b1;
    push(1'b1, st(SEL_NONE, 8'h00, 0, 0, 0, 0, 0), 1'b0, 2'd0);
    push(1'b0, vt[6].s1, 1'b1, 2'd1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset   = 1'b0;
    bus.run = 1'b0;
    #1;
    checks++;
    if (bus.Tstep_Q !== 2'd0 || bus.Rin !== 8'h00) begin
      errors++;
      $display("FAIL abort_state got tstep=%0d rin=%h expected tstep=0 rin=00", bus.Tstep_Q, bus.Rin);
    end
    model_cnt = 16'h0000;
    @(negedge clock); check_idle("abort_in_reset", 16'h0000);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); check_idle("idle_after_abort", 16'h0000);

    // 65536 retired mv instructions wrap the counter back to zero.
    @(posedge clock); #1;
    for (int k = 0; k < 65536; k++) exec(vt[0], (k != 65535), 1'b0);
    @(negedge clock);
    checks++;
    if (bus.instr_count !== 16'h0000) begin
      errors++;
      $display("FAIL count_wrap got %h expected 0000", bus.instr_count);
    end

    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
